goldschmidt_ctrl: RTL and testbench

GOLDSCHMIDT_CTRL -- requirements
Module: goldschmidt_ctrl

---
 rtl/goldschmidt_ctrl.sv | 120 ++++++++++++
 tb/tb_goldschmidt_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_ctrl.sv
// Sequencing controller for an iterative Goldschmidt divider.
// Steps the shared multiplier through N, D and k updates for ITERS iterations, then flags the quotient valid.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; ready high
// MUL_N | multiply the numerator path, load nNext (regA)
// MUL_D | multiply the divisor path, load dNext (regB)
// UPD_K | form the next correction factor, load kNext (regC)
// DONE  | quotient valid (or zero divisor reported) for one cycle
module goldschmidt_ctrl #(
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       d_zero,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic       muxSelA,
    output logic [1:0] muxSelB,
    output logic       regA,
    output logic       regB,
    output logic       regC,
    output logic [1:0] iter
);

    localparam logic [1:0] LAST_ITER = 2'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL_N = 3'd1,
        S_MUL_D = 3'd2,
        S_UPD_K = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] iter_nxt;
    logic       dbz_nxt;
    logic       first_iter;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            iter        <= 2'd0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            iter        <= iter_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        dbz_nxt   = div_by_zero;
        case (state)
            S_IDLE: begin
                if (start) begin
                    iter_nxt  = 2'd0;
                    dbz_nxt   = d_zero;
                    state_nxt = d_zero ? S_DONE : S_MUL_N;
                end
            end
            S_MUL_N: state_nxt = (iter == LAST_ITER) ? S_DONE : S_MUL_D;
            S_MUL_D: state_nxt = S_UPD_K;
            S_UPD_K: begin
                state_nxt = S_MUL_N;
                iter_nxt  = iter + 2'd1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are a pure decode of registered state/iter; inputs never reach them combinationally.
    assign first_iter = (iter == 2'd0);

    always_comb begin
        ready   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        muxSelA = 1'b0;
        muxSelB = 2'b00;
        regA    = 1'b0;
        regB    = 1'b0;
        regC    = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            S_MUL_N: begin
                regA    = 1'b1;
                muxSelA = first_iter;
                muxSelB = first_iter ? 2'b00 : 2'b10;
            end
            S_MUL_D: begin
                regB    = 1'b1;
                muxSelA = first_iter;
                muxSelB = first_iter ? 2'b01 : 2'b11;
            end
            S_UPD_K: begin
                regC    = 1'b1;
                muxSelB = 2'b00;
            end
            S_DONE:  done = 1'b1;
            default: begin
                ready = 1'b0;
                busy  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Randomised and directed bench for goldschmidt_ctrl (ITERS=3 and ITERS=1 instances side by side).
// Expected outputs come from a cycles-since-accept model of the operation schedule.
module tb_goldschmidt_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic d_zero = 1'b0;

    logic       ready3, busy3, done3, dbz3, sela3, rega3, regb3, regc3;
    logic [1:0] selb3, iter3;
    logic       ready1, busy1, done1, dbz1, sela1, rega1, regb1, regc1;
    logic [1:0] selb1, iter1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    goldschmidt_ctrl #(.ITERS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .d_zero(d_zero),
        .ready(ready3), .busy(busy3), .done(done3), .div_by_zero(dbz3),
        .muxSelA(sela3), .muxSelB(selb3), .regA(rega3), .regB(regb3), .regC(regc3),
        .iter(iter3)
    );

    goldschmidt_ctrl #(.ITERS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .d_zero(d_zero),
        .ready(ready1), .busy(busy1), .done(done1), .div_by_zero(dbz1),
        .muxSelA(sela1), .muxSelB(selb1), .regA(rega1), .regB(regb1), .regC(regc1),
        .iter(iter1)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    // {ready,busy,done,div_by_zero,muxSelA,muxSelB,regA,regB,regC,iter}
    function automatic logic [11:0] expv(int it, bit act, int pos, bit dz, bit dbz, logic [1:0] il);
        int s, k;
        logic sa;
        logic [1:0] sb;
        logic [2:0] en;
        if (!act) return {3'b100, dbz, 1'b0, 2'b00, 3'b000, il};
        if (dz) return {3'b011, dbz, 1'b0, 2'b00, 3'b000, 2'd0};
        if (pos == 3 * it - 1) return {3'b011, dbz, 1'b0, 2'b00, 3'b000, 2'(it - 1)};
        s = pos - 1;
        k = s / 3;
        case (s % 3)
            0: begin en = 3'b100; sa = (k == 0); sb = (k == 0) ? 2'b00 : 2'b10; end
            1: begin en = 3'b010; sa = (k == 0); sb = (k == 0) ? 2'b01 : 2'b11; end
            default: begin en = 3'b001; sa = 1'b0; sb = 2'b00; end
        endcase
        return {3'b010, dbz, sa, sb, en, 2'(k)};
    endfunction

    // Reference: per instance, whether an operation is live and how many cycles since it was accepted.
    int         its[2] = '{3, 1};
    bit         m_act[2];
    int         m_pos[2];
    bit         m_dz[2];
    bit         m_dbz[2];
    logic [1:0] m_il[2];

    always @(posedge clk or negedge reset) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                m_act[m] = 1'b0; m_pos[m] = 0; m_dz[m] = 1'b0; m_dbz[m] = 1'b0; m_il[m] = 2'd0;
            end else if (!m_act[m]) begin
                if (start) begin
                    m_act[m] = 1'b1; m_pos[m] = 1; m_dz[m] = d_zero; m_dbz[m] = d_zero; m_il[m] = 2'd0;
                end
            end else begin
                m_pos[m]++;
                if (m_pos[m] > (m_dz[m] ? 1 : 3 * its[m] - 1)) begin
                    m_act[m] = 1'b0;
                    m_il[m]  = m_dz[m] ? 2'd0 : 2'(its[m] - 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("it3_outs", {ready3, busy3, done3, dbz3, sela3, selb3, rega3, regb3, regc3, iter3},
                  expv(3, m_act[0], m_pos[0], m_dz[0], m_dbz[0], m_il[0]));
            check("it1_outs", {ready1, busy1, done1, dbz1, sela1, selb1, rega1, regb1, regc1, iter1},
                  expv(1, m_act[1], m_pos[1], m_dz[1], m_dbz[1], m_il[1]));
            check("it3_onehot", 12'($countones({rega3, regb3, regc3}) <= 1), 12'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        chk_en = 1'b1;
        cyc(3);
        reset = 1'b1;

        // single normal division
        start = 1'b1; d_zero = 1'b0;
        cyc(1); start = 1'b0;
        cyc(12);

        // starts while busy are ignored
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(2); start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(1); start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(8);

        // zero divisor, sticky flag, then cleared by a valid start
        start = 1'b1; d_zero = 1'b1;
        cyc(1); start = 1'b0; d_zero = 1'b0;
        cyc(6);
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(10);

        // async reset during UPD_K of iteration 1
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(5);
        #2 reset = 1'b0;
        #1;
        check("async_rst3", {ready3, busy3, done3, dbz3, sela3, selb3, rega3, regb3, regc3, iter3}, 12'b100000000000);
        check("async_rst1", {ready1, busy1, done1, dbz1, sela1, selb1, rega1, regb1, regc1, iter1}, 12'b100000000000);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(10);

        // start held high: back-to-back operations
        start = 1'b1;
        cyc(40);
        start = 1'b0;
        cyc(3);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            d_zero = ($urandom_range(0, 9) < 3);
            cyc(1);
        end
        start = 1'b0; d_zero = 1'b0;
        cyc(12);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
